pattern_seq_detector: RTL and testbench

Parametrised serial pattern detector: consumes one qualified bit per clock, tracks progress through a compile-time pattern of PAT_W bits, and reports completed matches and prefix aborts. It is the next generation of the team's fixed 4-bit "1100" detector, adding arbitrary pattern width, input qualification, a selectable resynchronisation policy, a synchronous clear and optional event counters. It sits directly on a serial bit stream, e.g. a deserialiser output or a GPIO sampler, upstream of control logic.

---
 rtl/pattern_seq_detector.sv | 145 ++++++++++++++
 tb/tb_pattern_seq_detector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_seq_detector.sv
// Serial pattern detector: tracks progress through PATTERN (MSB first), pulses on match/abort.
// Optional saturating event counters are built when PATTERN_SEQ_DETECTOR_COUNT_EN is defined.
module pattern_seq_detector #(
    parameter int unsigned       PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1100,
    parameter int unsigned       RESYNC  = 0,
    parameter int unsigned       CNT_W   = 8,
    parameter int unsigned       IDX_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             match,
    output logic             error,
    output logic [IDX_W-1:0] progress,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    logic [IDX_W-1:0] idx_r;
    logic             match_r;
    logic             error_r;

    state_t           state_s;
    logic [PAT_W-1:0] pat_shift_s;
    logic             bit_ok_s;
    logic             hit_s;
    logic             miss_s;
    logic [IDX_W-1:0] resync_idx_s;

    // Decode the expected bit at the current position and classify the incoming bit.
    always_comb begin
        state_s      = (idx_r == ZERO_IDX) ? IDLE : RUN;
        pat_shift_s  = PATTERN << idx_r;
        bit_ok_s     = (in_bit == pat_shift_s[PAT_W-1]);
        hit_s        = in_valid & bit_ok_s & (idx_r == LAST_IDX);
        miss_s       = in_valid & ~bit_ok_s & (state_s == RUN);
        if ((RESYNC != 32'd0) && (in_bit == PATTERN[PAT_W-1])) begin
            resync_idx_s = ONE_IDX;
        end else begin
            resync_idx_s = ZERO_IDX;
        end
    end

    // Progress FSM with registered match/error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= ZERO_IDX;
            match_r <= 1'b0;
            error_r <= 1'b0;
        end else if (clear) begin
            idx_r   <= ZERO_IDX;
            match_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            match_r <= hit_s;
            error_r <= miss_s;
            if (in_valid) begin
                case (state_s)
                    IDLE: begin
                        // PAT_W >= 2, so a single bit can never complete the pattern
                        if (bit_ok_s) begin
                            idx_r <= ONE_IDX;
                        end else begin
                            idx_r <= ZERO_IDX;
                        end
                    end
                    RUN: begin
                        if (bit_ok_s) begin
                            if (idx_r == LAST_IDX) begin
                                idx_r <= ZERO_IDX;
                            end else begin
                                idx_r <= idx_r + ONE_IDX;
                            end
                        end else begin
                            idx_r <= resync_idx_s;
                        end
                    end
                    default: idx_r <= ZERO_IDX;
                endcase
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    assign match    = match_r;
    assign error    = error_r;
    assign progress = idx_r;

`ifdef PATTERN_SEQ_DETECTOR_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] match_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == CNT_MAX) begin
            sat_inc = val;
        end else begin
            sat_inc = val + CNT_W'(1);
        end
    endfunction

    // Saturating counters, stepped on the same edge that raises the matching pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
        end else if (clear) begin
            match_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (hit_s) begin
                match_cnt_r <= sat_inc(match_cnt_r);
            end else begin
                match_cnt_r <= match_cnt_r;
            end
            if (miss_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign match_cnt = match_cnt_r;
    assign err_cnt   = err_cnt_r;
`else
    assign match_cnt = {CNT_W{1'b0}};
    assign err_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Randomized bench for pattern_seq_detector: three configurations share one stimulus stream
// and are compared each cycle against a prefix-length reference model.
module tb_pattern_seq_detector;

    logic clk;
    logic rst_n;
    logic clear;
    logic in_valid;
    logic in_bit;

    logic       m0, m1, m2, e0, e1, e2;
    logic [2:0] p0, p1, p2;
    logic [7:0] mc0, ec0, mc1, ec1;
    logic [1:0] mc2, ec2;

    pattern_seq_detector #(.PAT_W(4), .PATTERN(4'b1100), .RESYNC(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .match(m0), .error(e0), .progress(p0), .match_cnt(mc0), .err_cnt(ec0));
    pattern_seq_detector #(.PAT_W(4), .PATTERN(4'b1100), .RESYNC(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .match(m1), .error(e1), .progress(p1), .match_cnt(mc1), .err_cnt(ec1));
    pattern_seq_detector #(.PAT_W(4), .PATTERN(4'b1100), .RESYNC(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .match(m2), .error(e2), .progress(p2), .match_cnt(mc2), .err_cnt(ec2));

`ifdef PATTERN_SEQ_DETECTOR_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    int   n_tests;
    int   n_fail;
    logic [3:0] pat_v;

    // reference model state: length of the currently matched prefix plus event counts
    int   plen [3];
    int   mcnt [3];
    int   ecnt [3];
    int   cmax [3];
    bit   rsy  [3];
    bit   em   [3];
    bit   ee   [3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            plen[i] = 0; mcnt[i] = 0; ecnt[i] = 0; em[i] = 1'b0; ee[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic c, input logic v, input logic b);
        for (int i = 0; i < 3; i++) begin
            em[i] = 1'b0;
            ee[i] = 1'b0;
            if (c) begin
                plen[i] = 0; mcnt[i] = 0; ecnt[i] = 0;
            end else if (v) begin
                if (b == pat_v[3 - plen[i]]) begin
                    plen[i] = plen[i] + 1;
                    if (plen[i] == 4) begin
                        plen[i] = 0;
                        em[i] = 1'b1;
                        if (CNT_ON && mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
                    end
                end else if (plen[i] > 0) begin
                    ee[i] = 1'b1;
                    plen[i] = (rsy[i] && b == pat_v[3]) ? 1 : 0;
                    if (CNT_ON && ecnt[i] < cmax[i]) ecnt[i] = ecnt[i] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("d0_match", 32'(m0), 32'(em[0]));
        chk("d0_error", 32'(e0), 32'(ee[0]));
        chk("d0_prog",  32'(p0), 32'(plen[0]));
        chk("d0_mcnt",  32'(mc0), 32'(mcnt[0]));
        chk("d0_ecnt",  32'(ec0), 32'(ecnt[0]));
        chk("d1_match", 32'(m1), 32'(em[1]));
        chk("d1_error", 32'(e1), 32'(ee[1]));
        chk("d1_prog",  32'(p1), 32'(plen[1]));
        chk("d1_mcnt",  32'(mc1), 32'(mcnt[1]));
        chk("d1_ecnt",  32'(ec1), 32'(ecnt[1]));
        chk("d2_match", 32'(m2), 32'(em[2]));
        chk("d2_error", 32'(e2), 32'(ee[2]));
        chk("d2_prog",  32'(p2), 32'(plen[2]));
        chk("d2_mcnt",  32'(mc2), 32'(mcnt[2]));
        chk("d2_ecnt",  32'(ec2), 32'(ecnt[2]));
    endtask

    task automatic step(input logic c, input logic v, input logic b);
        clear = c; in_valid = v; in_bit = b;
        @(posedge clk);
        model_step(c, v, b);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_pat(input int gap);
        logic [3:0] p;
        p = pat_v;
        for (int k = 3; k >= 0; k--) begin
            step(1'b0, 1'b1, p[k]);
            if (k > 0) for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        logic [5:0] s6;
        n_tests = 0; n_fail = 0;
        pat_v = 4'b1100;
        cmax[0] = 255; cmax[1] = 255; cmax[2] = 3;
        rsy[0] = 1'b0; rsy[1] = 1'b1; rsy[2] = 1'b0;
        clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; rst_n = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // single clean pattern
        send_pat(0);
        chk("tp_match_pulse", 32'(m0), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("tp_match_drop", 32'(m0), 32'd0);

        // 1,1,1,1,0,0 against both resync policies
        s6 = 6'b111100;
        for (int k = 5; k >= 0; k--) step(1'b0, 1'b1, s6[k]);
        step(1'b0, 1'b0, 1'b0);

        // gaps of 0,3,1 idle cycles between bits
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        // five back-to-back patterns saturate the 2-bit counter
        for (int n = 0; n < 5; n++) send_pat(0);
        chk("tp_sat", 32'(mc2), CNT_ON ? 32'd3 : 32'd0);
        step(1'b1, 1'b1, 1'b1);

        // reset mid-pattern, then a normal match
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        do_reset();
        send_pat(0);
        chk("tp_after_rst", 32'(m0), 32'd1);

        // clear mid-pattern
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("tp_clear_prog", 32'(p0), 32'd0);

        // random stream biased toward valid bits
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                     1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
